// File: rtl/modexp_ctrl_pkg.sv
// Shared RSA definitions: default operand width and the modular-exponentiation
// controller state encoding.
package modexp_ctrl_pkg;

    localparam int unsigned MODEXP_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SQR,
        ST_MUL,
        ST_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply controller computing base^exp mod n, with
// each reduction done by an external registered modulo LUT.
module modexp_ctrl
    import modexp_ctrl_pkg::*;
#(
    parameter int unsigned W = MODEXP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     base,
    input  logic [W-1:0]     exp,
    input  logic [W-1:0]     n,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     result,
    output logic             err,
    output logic [2*W-1:0]   lut_func_in,
    output logic [W-1:0]     lut_div,
    input  logic [W-1:0]     lut_func_out
);

    localparam int unsigned KW    = (W > 1) ? $clog2(W) : 1;
    localparam logic [KW-1:0] K_MAX = KW'(W - 1);

    state_t         state;
    state_t         state_next;
    state_t         last_op;
    logic [KW-1:0]  k;
    logic [W-1:0]   acc;
    logic [W-1:0]   base_q;
    logic [W-1:0]   exp_q;
    logic [W-1:0]   n_q;
    state_t         advance;

    assign lut_div = n_q;
    assign advance = (k == '0) ? ST_DONE : ST_SQR;

    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        lut_func_in = '0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = (n == '0) ? ST_DONE : ST_INIT;
            end
            ST_INIT: begin
                busy        = 1'b1;
                lut_func_in = (2*W)'(1);
                state_next  = ST_WAIT;
            end
            ST_SQR: begin
                busy        = 1'b1;
                lut_func_in = (2*W)'(acc) * (2*W)'(acc);
                state_next  = ST_WAIT;
            end
            ST_MUL: begin
                busy        = 1'b1;
                lut_func_in = (2*W)'(acc) * (2*W)'(base_q);
                state_next  = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                // last_op tells which issue state this reduction belongs to
                case (last_op)
                    ST_INIT: state_next = ST_SQR;
                    ST_SQR:  state_next = exp_q[k] ? ST_MUL : advance;
                    default: state_next = advance;
                endcase
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            last_op <= ST_IDLE;
            k       <= K_MAX;
            acc     <= '0;
            base_q  <= '0;
            exp_q   <= '0;
            n_q     <= '0;
            result  <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && start) begin
                base_q <= base;
                exp_q  <= exp;
                n_q    <= n;
                k      <= K_MAX;
                if (n == '0) begin
                    result <= '0;
                    err    <= 1'b1;
                end
            end
            if (state == ST_INIT || state == ST_SQR || state == ST_MUL)
                last_op <= state;
            if (state == ST_WAIT) begin
                acc <= lut_func_out;
                // INIT's reduction starts bit W-1 without moving k
                if (state_next == ST_SQR && last_op != ST_INIT)
                    k <= k - KW'(1);
                if (state_next == ST_DONE) begin
                    result <= lut_func_out;
                    err    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Directed bench for modexp_ctrl with a behavioural registered modulo LUT.
module tb_modexp_ctrl;

    localparam int unsigned W = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   base;
    logic [W-1:0]   exp_v;
    logic [W-1:0]   n;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic           err;
    logic [2*W-1:0] lut_func_in;
    logic [W-1:0]   lut_div;
    logic [W-1:0]   lut_func_out = '0;

    int vectors     = 0;
    int miscompares = 0;

    modexp_ctrl #(.W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base         (base),
        .exp          (exp_v),
        .n            (n),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .err          (err),
        .lut_func_in  (lut_func_in),
        .lut_div      (lut_div),
        .lut_func_out (lut_func_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        lut_func_out <= (lut_div == '0) ? '0 : W'(lut_func_in % (2*W)'(lut_div));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    // Entered and left at a falling edge.
    task automatic run(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                       input logic [W-1:0] want_res, input logic want_err,
                       input int want_busy, input bit perturb);
        logic [W-1:0] prev;
        int  cnt;
        int  extra;
        bit  seen;
        bit  lut_nz;
        prev   = result;
        base   = b;
        exp_v  = e;
        n      = m;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cnt    = 0;
        seen   = 1'b0;
        lut_nz = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (lut_func_in != '0) lut_nz = 1'b1;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) cnt++;
                check("result_hold", 32'(result), 32'(prev));
                if (perturb && c == 4) begin
                    start = 1'b1;
                    base  = ~b;
                    exp_v = ~e;
                    n     = m + W'(1);
                end
                if (perturb && c == 5) start = 1'b0;
            end
        end
        check("done_seen", 32'(seen), 32'(1));
        check("busy_cycles", 32'(cnt), 32'(want_busy));
        check("result", 32'(result), 32'(want_res));
        check("err", 32'(err), 32'(want_err));
        if (m == '0) check("lut_idle_n0", 32'(lut_nz), 32'(0));
        @(negedge clk);
        check("done_pulse_end", 32'(done), 32'(0));
        check("busy_after_done", 32'(busy), 32'(0));
        if (perturb) begin
            extra = 0;
            repeat (30) begin
                @(negedge clk);
                if (done) extra++;
            end
            check("no_extra_done", 32'(extra), 32'(0));
            check("result_kept", 32'(result), 32'(want_res));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        base  = '0;
        exp_v = '0;
        n     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_result", 32'(result), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_lut_in", 32'(lut_func_in), 32'(0));
        rst = 1'b0;

        run(6'd7,  6'd5,  6'd33, 6'd10, 1'b0, 18, 1'b0);
        run(6'd8,  6'd3,  6'd55, 6'd17, 1'b0, 18, 1'b0);
        run(6'd17, 6'd27, 6'd55, 6'd8,  1'b0, 22, 1'b0);
        run(6'd9,  6'd0,  6'd1,  6'd0,  1'b0, 14, 1'b0);
        run(6'd9,  6'd0,  6'd5,  6'd1,  1'b0, 14, 1'b0);
        run(6'd9,  6'd3,  6'd0,  6'd0,  1'b1, 0,  1'b0);
        run(6'd40, 6'd1,  6'd7,  6'd5,  1'b0, 16, 1'b0);
        run(6'd8,  6'd3,  6'd55, 6'd17, 1'b0, 18, 1'b1);

        // Abort a run in its fifth busy cycle
        base  = 6'd7;
        exp_v = 6'd5;
        n     = 6'd33;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_result", 32'(result), 32'(0));
        check("abort_err", 32'(err), 32'(0));
        check("abort_lut_in", 32'(lut_func_in), 32'(0));
        rst = 1'b0;
        run(6'd7, 6'd5, 6'd33, 6'd10, 1'b0, 18, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
